// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between IF and the
// memory controller; hits answer the cycle after lookup, misses fill one word.
module icache #(
    parameter int INDEX_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        jp_wrong,
    input  logic [31:0] pc_in,
    output logic        ins_flag,
    output logic [31:0] ins,
    output logic        mc_req,
    output logic [31:0] mc_addr,
    input  logic        mc_done,
    input  logic [31:0] mc_data
);

    localparam int TAG_W = 30 - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t state;
    logic   flushed;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags  [LINES];
    logic [31:0]      datas [LINES];

    logic [INDEX_W-1:0] pc_idx;
    logic [TAG_W-1:0]   pc_tag;
    logic [INDEX_W-1:0] fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               hit;
    logic               fill;
    logic               unused_pc_lsb;

    assign pc_idx        = pc_in[INDEX_W+1:2];
    assign pc_tag        = pc_in[31:INDEX_W+2];
    assign fill_idx      = mc_addr[INDEX_W+1:2];
    assign fill_tag      = mc_addr[31:INDEX_W+2];
    assign hit           = valid[pc_idx] && (tags[pc_idx] == pc_tag);
    assign fill          = !rst && rdy && (state == MISS) && mc_done;
    assign unused_pc_lsb = ^pc_in[1:0];

    // Tag/data arrays carry no reset so they can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (fill) begin
            tags[fill_idx]  <= fill_tag;
            datas[fill_idx] <= mc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            flushed  <= 1'b0;
            valid    <= '0;
            ins_flag <= 1'b0;
            ins      <= 32'h0;
            mc_req   <= 1'b0;
            mc_addr  <= 32'h0;
        end else if (rdy) begin
            unique case (state)
                IDLE: begin
                    if (jp_wrong) begin
                        ins_flag <= 1'b0;
                    end else if (hit) begin
                        ins_flag <= 1'b1;
                        ins      <= datas[pc_idx];
                    end else begin
                        ins_flag <= 1'b0;
                        mc_req   <= 1'b1;
                        mc_addr  <= {pc_in[31:2], 2'b00};
                        state    <= MISS;
                    end
                end
                MISS: begin
                    ins_flag <= 1'b0;
                    if (mc_done) begin
                        // The fill is kept even when squashed: the word is still good.
                        valid[fill_idx] <= 1'b1;
                        mc_req          <= 1'b0;
                        flushed         <= 1'b0;
                        state           <= IDLE;
                        if (!(flushed || jp_wrong)) begin
                            ins_flag <= 1'b1;
                            ins      <= mc_data;
                        end
                    end else if (jp_wrong) begin
                        flushed <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Randomized scoreboard bench for icache against a line-map reference model.
// Expected per-cycle outputs are queued by the driver and checked by a monitor.
module tb_icache;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        jp_wrong;
    logic [31:0] pc_in;
    logic        ins_flag;
    logic [31:0] ins;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_done;
    logic [31:0] mc_data;

    icache #(.INDEX_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .jp_wrong (jp_wrong),
        .pc_in    (pc_in),
        .ins_flag (ins_flag),
        .ins      (ins),
        .mc_req   (mc_req),
        .mc_addr  (mc_addr),
        .mc_done  (mc_done),
        .mc_data  (mc_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        flag;
        bit [31:0] ins;
        bit        req;
        bit [31:0] addr;
        int        tag;
    } exp_t;

    exp_t q[$];
    int   n_cmp;
    int   n_bad;
    int   step_no;

    // Reference model: which word each line currently holds, and its data.
    bit [31:0] line_addr [int];
    bit [31:0] line_data [int];
    bit        m_busy;
    bit        m_flushed;
    bit        m_flag;
    bit [31:0] m_ins;
    bit        m_req;
    bit [31:0] m_addr;

    function automatic int idx_of(input bit [31:0] a);
        return int'(a[9:2]);
    endfunction

    task automatic model(input bit r, input bit en, input bit jp,
                         input bit [31:0] pc, input bit dn,
                         input bit [31:0] dat);
        bit [31:0] wa;
        int        ix;
        wa = {pc[31:2], 2'b00};
        ix = idx_of(pc);
        if (r) begin
            line_addr.delete();
            line_data.delete();
            m_busy    = 0;
            m_flushed = 0;
            m_flag    = 0;
            m_ins     = 0;
            m_req     = 0;
            m_addr    = 0;
        end else if (en) begin
            if (!m_busy) begin
                if (jp) begin
                    m_flag = 0;
                end else if (line_addr.exists(ix) && line_addr[ix] == wa) begin
                    m_flag = 1;
                    m_ins  = line_data[ix];
                end else begin
                    m_flag = 0;
                    m_req  = 1;
                    m_addr = wa;
                    m_busy = 1;
                end
            end else begin
                m_flag = 0;
                if (dn) begin
                    line_addr[idx_of(m_addr)] = m_addr;
                    line_data[idx_of(m_addr)] = dat;
                    m_req = 0;
                    if (!(m_flushed || jp)) begin
                        m_flag = 1;
                        m_ins  = dat;
                    end
                    m_flushed = 0;
                    m_busy    = 0;
                end else if (jp) begin
                    m_flushed = 1;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit en, input bit jp,
                        input bit [31:0] pc, input bit dn,
                        input bit [31:0] dat);
        exp_t e;
        @(negedge clk);
        rst      = r;
        rdy      = en;
        jp_wrong = jp;
        pc_in    = pc;
        mc_done  = dn;
        mc_data  = dat;
        model(r, en, jp, pc, dn, dat);
        step_no++;
        e.flag = m_flag;
        e.ins  = m_ins;
        e.req  = m_req;
        e.addr = m_addr;
        e.tag  = step_no;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                n_cmp++;
                if (ins_flag !== e.flag) begin
                    n_bad++;
                    $display("FAIL ins_flag step %0d: got %b want %b",
                             e.tag, ins_flag, e.flag);
                end
                n_cmp++;
                if (mc_req !== e.req) begin
                    n_bad++;
                    $display("FAIL mc_req step %0d: got %b want %b",
                             e.tag, mc_req, e.req);
                end
                n_cmp++;
                if (mc_addr !== e.addr) begin
                    n_bad++;
                    $display("FAIL mc_addr step %0d: got %h want %h",
                             e.tag, mc_addr, e.addr);
                end
                if (e.flag) begin
                    n_cmp++;
                    if (ins !== e.ins) begin
                        n_bad++;
                        $display("FAIL ins step %0d: got %h want %h",
                                 e.tag, ins, e.ins);
                    end
                end
            end
        end
    end

    function automatic bit [31:0] rand_pc();
        bit [31:0] t;
        bit [31:0] i;
        t = 32'($urandom_range(0, 3));
        if (t == 3) t = 32'h003F_FFFF;
        i = 32'($urandom_range(0, 7));
        return (t << 10) | (i << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin : driver
        bit        r;
        bit        en;
        bit        jp;
        bit        dn;
        bit [31:0] pc;
        n_cmp    = 0;
        n_bad    = 0;
        step_no  = 0;
        rst      = 1;
        rdy      = 1;
        jp_wrong = 0;
        pc_in    = 0;
        mc_done  = 0;
        mc_data  = 0;

        // Cold miss, then hit
        step(1, 1, 0, 32'h0, 0, 0);
        step(0, 1, 0, 32'h0, 0, 0);
        step(0, 1, 0, 32'h0, 0, 0);
        step(0, 1, 0, 32'h0, 0, 0);
        step(0, 1, 0, 32'h0, 1, 32'h0000_0013);
        step(0, 1, 0, 32'h0, 0, 0);
        // Conflict on index 0
        step(0, 1, 0, 32'h400, 0, 0);
        step(0, 1, 0, 32'h400, 1, 32'hAAAA_0000);
        step(0, 1, 0, 32'h400, 0, 0);
        step(0, 1, 0, 32'h0, 0, 0);
        step(0, 1, 0, 32'h0, 1, 32'h0000_0013);
        // Squash during miss, line still filled
        step(0, 1, 0, 32'h8, 0, 0);
        step(0, 1, 1, 32'h8, 0, 0);
        step(0, 1, 0, 32'h8, 0, 0);
        step(0, 1, 0, 32'h8, 1, 32'h0000_0055);
        step(0, 1, 0, 32'h8, 0, 0);
        // Freeze mid-miss
        step(0, 1, 0, 32'hC, 0, 0);
        repeat (4) step(0, 0, 0, 32'hC, 0, 0);
        step(0, 1, 0, 32'hC, 0, 0);
        step(0, 1, 0, 32'hC, 1, 32'h1234_5678);
        step(0, 1, 0, 32'hC, 0, 0);
        // Reset mid-miss, stray done ignored
        step(0, 1, 0, 32'h10, 0, 0);
        step(1, 1, 0, 32'h10, 0, 0);
        step(0, 1, 0, 32'h10, 1, 32'h0000_0077);
        step(0, 1, 0, 32'h10, 1, 32'h0000_0088);
        step(0, 1, 0, 32'h10, 0, 0);
        step(0, 1, 0, 32'h0, 0, 0);

        for (int k = 0; k < 3000; k++) begin
            r  = ($urandom_range(0, 299) == 0);
            en = ($urandom_range(0, 7) != 0);
            jp = ($urandom_range(0, 9) == 0);
            dn = m_busy && en && ($urandom_range(0, 2) == 0);
            pc = rand_pc();
            step(r, en, jp, pc, dn, $urandom);
        end

        @(negedge clk);
        rdy = 0;
        @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d left want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
